// File: rtl/parking_lot_ctrl.sv
// Parking-lot controller: synchronises and debounces presence sensors, drives spot LEDs,
// runs entrance/exit gate FSMs and tracks the number of cars inside the lot.
module parking_lot_ctrl #(
  parameter int unsigned N_SPOTS          = 3,
  parameter int unsigned DEBOUNCE_CYCLES  = 4,
  parameter int unsigned GATE_HOLD_CYCLES = 8,
  parameter int unsigned CNT_W            = $clog2(N_SPOTS + 1)
) (
  input  logic               CLOCK_50,
  input  logic               reset_n,
  input  logic [N_SPOTS-1:0] spot_presence,
  input  logic               entr_presence,
  input  logic               exit_presence,
  output logic [N_SPOTS-1:0] spot_led,
  output logic               full_led,
  output logic               open_entrance,
  output logic               open_exit,
  output logic [CNT_W-1:0]   lot_count,
  output logic [CNT_W-1:0]   spots_taken
);

  localparam int unsigned N_IN   = N_SPOTS + 2;
  localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned HOLD_W = (GATE_HOLD_CYCLES > 1) ? $clog2(GATE_HOLD_CYCLES) : 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(GATE_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(N_SPOTS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OPEN = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // Gate index 0 is the entrance, 1 is the exit.
  localparam int unsigned G_ENTR = 0;
  localparam int unsigned G_EXIT = 1;

  // ---------------------------------------------------------------------------
  // Synchroniser: bit layout {exit, entr, spots}
  // ---------------------------------------------------------------------------
  logic [N_IN-1:0] raw;
  logic [N_IN-1:0] sync1_q;
  logic [N_IN-1:0] sync2_q;

  assign raw = {exit_presence, entr_presence, spot_presence};

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Debouncer: flip only after DEBOUNCE_CYCLES consecutive differing samples
  // ---------------------------------------------------------------------------
  logic [N_IN-1:0] db_q;
  logic [N_IN-1:0] db_d;
  logic [DB_W-1:0] db_cnt_q [N_IN];
  logic [DB_W-1:0] db_cnt_d [N_IN];

  always_comb begin
    db_d = db_q;
    for (int i = 0; i < N_IN; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          db_d[i] = ~db_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      db_q <= '0;
      for (int i = 0; i < N_IN; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      db_q <= db_d;
      for (int i = 0; i < N_IN; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Spot LEDs and occupancy popcount
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]   taken_d;
  logic [N_SPOTS-1:0] spot_led_q;
  logic [CNT_W-1:0]   taken_q;

  always_comb begin
    taken_d = '0;
    for (int i = 0; i < N_SPOTS; i++) begin
      taken_d = taken_d + CNT_W'(db_q[i]);
    end
  end

  // ---------------------------------------------------------------------------
  // Gate FSMs
  // ---------------------------------------------------------------------------
  logic [1:0]        gate_st_q [2];
  logic [1:0]        gate_st_d [2];
  logic [HOLD_W-1:0] hold_q    [2];
  logic [HOLD_W-1:0] hold_d    [2];
  logic [1:0]        gate_sense;
  logic [1:0]        gate_allow;
  logic [1:0]        gate_pulse;
  logic [1:0]        gate_open_d;
  logic [1:0]        gate_open_q;
  logic [CNT_W-1:0]  lot_q;
  logic [CNT_W-1:0]  lot_d;

  assign gate_sense = {db_q[N_SPOTS+1], db_q[N_SPOTS]};
  // Exit is never refused; entrance looks at the live count, not the registered LED.
  assign gate_allow = {1'b1, (lot_q < CNT_MAX)};

  always_comb begin
    for (int g = 0; g < 2; g++) begin
      gate_st_d[g]  = gate_st_q[g];
      hold_d[g]     = hold_q[g];
      gate_pulse[g] = 1'b0;
      case (gate_st_q[g])
        ST_IDLE: begin
          if (gate_sense[g] && gate_allow[g]) begin
            gate_st_d[g] = ST_OPEN;
          end
        end
        ST_OPEN: begin
          if (!gate_sense[g]) begin
            gate_st_d[g]  = ST_HOLD;
            hold_d[g]     = '0;
            gate_pulse[g] = 1'b1;
          end
        end
        ST_HOLD: begin
          if (gate_sense[g]) begin
            gate_st_d[g] = ST_OPEN;
          end else if (hold_q[g] == HOLD_LAST) begin
            gate_st_d[g] = ST_IDLE;
          end else begin
            hold_d[g] = hold_q[g] + HOLD_W'(1);
          end
        end
        default: gate_st_d[g] = ST_IDLE;
      endcase
      // Decode the next state so the registered command lines up with the state register.
      gate_open_d[g] = (gate_st_d[g] == ST_OPEN) || (gate_st_d[g] == ST_HOLD);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int g = 0; g < 2; g++) begin
        gate_st_q[g] <= ST_IDLE;
        hold_q[g]    <= '0;
      end
      gate_open_q <= '0;
    end else begin
      for (int g = 0; g < 2; g++) begin
        gate_st_q[g] <= gate_st_d[g];
        hold_q[g]    <= hold_d[g];
      end
      gate_open_q <= gate_open_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Car counter: simultaneous inc and dec cancel
  // ---------------------------------------------------------------------------
  always_comb begin
    lot_d = lot_q;
    if (gate_pulse[G_ENTR] && !gate_pulse[G_EXIT] && (lot_q != CNT_MAX)) begin
      lot_d = lot_q + CNT_W'(1);
    end else if (gate_pulse[G_EXIT] && !gate_pulse[G_ENTR] && (lot_q != '0)) begin
      lot_d = lot_q - CNT_W'(1);
    end
  end

  logic full_q;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      lot_q      <= '0;
      full_q     <= 1'b0;
      spot_led_q <= '0;
      taken_q    <= '0;
    end else begin
      lot_q      <= lot_d;
      full_q     <= (lot_q == CNT_MAX);
      spot_led_q <= db_q[N_SPOTS-1:0];
      taken_q    <= taken_d;
    end
  end

  assign spot_led      = spot_led_q;
  assign spots_taken   = taken_q;
  assign full_led      = full_q;
  assign lot_count     = lot_q;
  assign open_entrance = gate_open_q[G_ENTR];
  assign open_exit     = gate_open_q[G_EXIT];

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Scoreboard bench for parking_lot_ctrl: stimulus queues expected output snapshots with their
// cycle of appearance; a monitor pops one entry every time the DUT outputs change.
module tb_parking_lot_ctrl;

  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] spot_p = '0;
  logic         entr_p = 1'b0;
  logic         exit_p = 1'b0;
  logic [N-1:0] spot_led;
  logic         full_led;
  logic         open_entrance;
  logic         open_exit;
  logic [1:0]   lot_count;
  logic [1:0]   spots_taken;

  parking_lot_ctrl #(
    .N_SPOTS         (N),
    .DEBOUNCE_CYCLES (4),
    .GATE_HOLD_CYCLES(8),
    .CNT_W           (2)
  ) dut (
    .CLOCK_50     (clk),
    .reset_n      (rst_n),
    .spot_presence(spot_p),
    .entr_presence(entr_p),
    .exit_presence(exit_p),
    .spot_led     (spot_led),
    .full_led     (full_led),
    .open_entrance(open_entrance),
    .open_exit    (open_exit),
    .lot_count    (lot_count),
    .spots_taken  (spots_taken)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         at;
    logic [9:0] val;
  } exp_t;
  exp_t sb[$];

  // Expected output model
  logic [N-1:0] e_spot = '0;
  logic         e_full = 1'b0;
  logic         e_oe = 1'b0;
  logic         e_ox = 1'b0;
  logic [1:0]   e_lot = '0;
  logic [1:0]   e_taken = '0;

  logic [9:0] obs;
  assign obs = {spot_led, full_led, open_entrance, open_exit, lot_count, spots_taken};

  function automatic logic [9:0] pack_exp();
    return {e_spot, e_full, e_oe, e_ox, e_lot, e_taken};
  endfunction

  task automatic push(input int at);
    exp_t e;
    e.at  = at;
    e.val = pack_exp();
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [9:0] got, input logic [9:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b, required %b", name, got, want);
    end
  endtask

  // Monitor: every output change must match the next queued snapshot at its cycle.
  initial begin
    logic [9:0] prev;
    exp_t       e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = obs;
      end else if (obs !== prev) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: cycle %0d got %b, required no change from %b",
                   cyc, obs, prev);
        end else begin
          e = sb.pop_front();
          if (obs !== e.val || cyc != e.at) begin
            errors++;
            $display("FAIL output_event: cycle %0d got %b, required %b at cycle %0d",
                     cyc, obs, e.val, e.at);
          end
        end
        prev = obs;
      end
    end
  end

  // Full gate pass: sensor high for hold cycles then low; lot_after is the hand-computed count.
  task automatic gate_cycle(input bit ex, input int hold, input int lot_after);
    int c;
    bit was_full;
    c = cyc;
    if (ex) begin exit_p = 1'b1; e_ox = 1'b1; end
    else    begin entr_p = 1'b1; e_oe = 1'b1; end
    push(c + 7);
    tick(hold);
    c = cyc;
    if (ex) exit_p = 1'b0;
    else    entr_p = 1'b0;
    if (lot_after != int'(e_lot)) begin
      was_full = (e_lot == 2'd3);
      e_lot    = 2'(lot_after);
      push(c + 7);
      if ((lot_after == 3) != was_full) begin
        e_full = (lot_after == 3);
        push(c + 8);
      end
    end
    if (ex) e_ox = 1'b0;
    else    e_oe = 1'b0;
    push(c + 15);
    tick(25);
  endtask

  logic [N-1:0] spot_vec [4];
  logic [1:0]   spot_cnt [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c;
    spot_vec = '{3'b010, 3'b111, 3'b101, 3'b000};
    spot_cnt = '{2'd1, 2'd3, 2'd2, 2'd0};

    tick(3);
    check("reset_outputs", obs, 10'b0);
    rst_n = 1'b1;
    tick(3);

    // Short glitch on spot 1 must be filtered out.
    spot_p = 3'b010;
    tick(3);
    spot_p = 3'b000;
    tick(15);
    check("spot_glitch", {7'b0, spot_led}, 10'b0);

    // Stable spot patterns: LED and popcount 7 cycles after the drive.
    for (int i = 0; i < 4; i++) begin
      c       = cyc;
      spot_p  = spot_vec[i];
      e_spot  = spot_vec[i];
      e_taken = spot_cnt[i];
      push(c + 7);
      tick(12);
    end

    // Entry cycle, then fill the lot.
    gate_cycle(1'b0, 20, 1);
    gate_cycle(1'b0, 10, 2);
    gate_cycle(1'b0, 10, 3);
    check("full_count", {7'b0, full_led, lot_count}, {7'b0, 1'b1, 2'd3});

    // Fourth car waits; it is refused until an exit frees a space.
    entr_p = 1'b1;
    tick(20);
    check("refused_gate", {9'b0, open_entrance}, 10'b0);
    c      = cyc;
    exit_p = 1'b1;
    e_ox   = 1'b1;
    push(c + 7);
    tick(10);
    c      = cyc;
    exit_p = 1'b0;
    e_lot  = 2'd2;
    push(c + 7);
    e_oe   = 1'b1;
    e_full = 1'b0;
    push(c + 8);
    e_ox   = 1'b0;
    push(c + 15);
    tick(20);
    c      = cyc;
    entr_p = 1'b0;
    e_lot  = 2'd3;
    push(c + 7);
    e_full = 1'b1;
    push(c + 8);
    e_oe   = 1'b0;
    push(c + 15);
    tick(25);

    // Back to two cars, then simultaneous entry and exit leave the count unchanged.
    gate_cycle(1'b1, 10, 2);
    c      = cyc;
    entr_p = 1'b1;
    exit_p = 1'b1;
    e_oe   = 1'b1;
    e_ox   = 1'b1;
    push(c + 7);
    tick(10);
    c      = cyc;
    entr_p = 1'b0;
    exit_p = 1'b0;
    e_oe   = 1'b0;
    e_ox   = 1'b0;
    push(c + 15);
    tick(25);
    check("simultaneous_count", {8'b0, lot_count}, 10'd2);

    // Empty the lot, then one more exit must not underflow.
    gate_cycle(1'b1, 10, 1);
    gate_cycle(1'b1, 10, 0);
    gate_cycle(1'b1, 10, 0);
    check("exit_saturate", {8'b0, lot_count}, 10'd0);

    // Reset mid-operation with the entrance gate open and two cars inside.
    gate_cycle(1'b0, 10, 1);
    gate_cycle(1'b0, 10, 2);
    c      = cyc;
    entr_p = 1'b1;
    e_oe   = 1'b1;
    push(c + 7);
    tick(10);
    check("pre_reset_open", {9'b0, open_entrance}, 10'd1);
    rst_n  = 1'b0;
    entr_p = 1'b0;
    #1;
    check("reset_async", obs, 10'b0);
    e_spot = '0; e_full = 1'b0; e_oe = 1'b0; e_ox = 1'b0; e_lot = '0; e_taken = '0;
    tick(3);
    rst_n = 1'b1;
    tick(5);
    check("post_reset", obs, 10'b0);
    gate_cycle(1'b0, 10, 1);

    tick(40);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending events, required 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
